mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported RAM between the datapath's instruction-fetch and data requests.
- Sits between the datapath/cache interface and the RAM model.
- Sequences each access through a request/issue/response FSM. Data requests have priority, bounded by an anti-starvation counter for instruction fetch.
- Generates the ihit/dhit pulses the datapath control and request units stall on. Handles RAM errors by bounded retry.

Parameters:
- STARVE_LIMIT, 4: max consecutive data grants while iREN is pending; the next grant then goes to ifetch.
- MAX_RETRY, 2: RAM ERROR retries per transaction before aborting.
- ERR_WORD, 32'hBAD1BAD1: load value returned on an aborted read.

Ports:
- CLK  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request (level)
- iaddr  in  32  instruction word address
- dREN  in  1  data read request (level)
- dWEN  in  1  data write request (level)
- daddr  in  32  data address
- dstore  in  32  data write value
- ihit  out  1  one-cycle instruction completion pulse
- iload  out  32  fetched instruction, valid with ihit
- dhit  out  1  one-cycle data completion pulse
- dload  out  32  read data, valid with dhit
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramstate  in  2  ramstate_t: FREE/BUSY/ACCESS/ERROR
- ramload  in  32  RAM read data
- err  out  1  sticky abort flag, cleared only by reset

Behaviour:
- Reset (async, nRST=0): state=IDLE.
  - All outputs 0: hit, load, RAM strobes/addr/store, err.
  - starve_cnt=0, retry_cnt=0.
- States: IDLE, IFETCH, DREAD, DWRITE, RESP.
- IDLE grant selection:
  - Write requests: dWEN -> DWRITE; dWEN and dREN both high is treated as a write.
  - Read requests: dREN -> DREAD.
  - Instruction requests: iREN -> IFETCH.
  - Priority: data beats instruction, except when starve_cnt==STARVE_LIMIT and iREN=1, which grants IFETCH.
- Grant latching: on the grant, the address, store data and request type are captured into registers. RAM outputs are driven only from these registers, so they are stable even if inputs change mid-access.
- starve_cnt:
  - Increments on each data grant made while iREN=1.
  - Clears on an IFETCH grant, or on any grant with iREN=0.
  - Saturates at STARVE_LIMIT.
- Issue states: ramREN (IFETCH/DREAD) or ramWEN (DWRITE) is asserted every cycle in the state. The FSM holds while ramstate is FREE or BUSY.
- ramstate==ACCESS: capture ramload (reads) -> RESP.
- ramstate==ERROR:
  - If retry_cnt<MAX_RETRY: increment retry_cnt, deassert strobes for one cycle, then re-issue.
  - Else: set err, capture ERR_WORD (reads) -> RESP.
- RESP:
  - Pulse ihit (IFETCH) or dhit (DREAD/DWRITE) for exactly one cycle, with the registered load word.
  - Strobes are 0. retry_cnt clears. Next state is IDLE.
- Latency: request seen in IDLE at cycle 0; issue at cycle 1; with k wait cycles, ACCESS at cycle 1+k; hit at cycle 2+k.
  - Minimum latency is 2 cycles, so back-to-back requests get at most one grant per 3 cycles.
- Withdrawn request: if the granted request line drops before RESP, the RAM access still completes (a write still commits) but the hit pulse is suppressed. iload/dload still update.
- Never assert ihit and dhit in the same cycle. Never assert ramREN and ramWEN together.
- Out-of-enum ramstate is treated as BUSY.
- nRST asserted mid-transaction aborts immediately: strobes drop asynchronously and no hit is issued.

Decomposition:
- diaosi_types_pkg gains:
  - arb_state_t enum {IDLE, IFETCH, DREAD, DWRITE, RESP}
  - arb_req_t enum {REQ_I, REQ_DR, REQ_DW}
- ramstate_t and word_t come from cpu_types_pkg.
- Single module with no sub-modules; starvation and retry counters are inline registers.

Test Plan:
- Ifetch only: iREN=1, iaddr=0x40, ramstate ACCESS on first issue cycle, ramload=0x8C220004 -> ihit=1 at cycle 2 with iload=0x8C220004; ramREN high only in cycle 1.
- Data priority: iREN and dREN both high, daddr=0x100, ramload=0x12345678 -> DREAD granted first, dhit with dload=0x12345678, then IFETCH completes with ihit.
- Starvation: iREN held high, dREN held high for 10 grants, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
- Write with wait states: dWEN=1, daddr=0x200, dstore=0xDEADBEEF, ramstate BUSY for 3 cycles then ACCESS -> ramWEN/ramaddr/ramstore stable for 4 cycles, dhit at cycle 5, no ihit.
- Error retry and abort: ramstate=ERROR on every issue cycle for a DREAD -> 3 issue attempts separated by gap cycles, then dhit with dload=0xBAD1BAD1, err=1 held until nRST.
- Mid-access reset: nRST pulled low during DWRITE BUSY -> ramWEN=0 immediately, no dhit, state IDLE after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-level types: machine word and RAM handshake state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// Memory-arbiter FSM states and latched request kinds.
package diaosi_types_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IFETCH,
    DREAD,
    DWRITE,
    RESP
  } arb_state_t;

  typedef enum logic [1:0] {
    REQ_I,
    REQ_DR,
    REQ_DW
  } arb_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-ported RAM between ifetch and data requests,
// data-first with ifetch anti-starvation and bounded ERROR retry.
module mem_arbiter
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;
#(
  parameter int    STARVE_LIMIT = 4,
  parameter int    MAX_RETRY    = 2,
  parameter word_t ERR_WORD     = 32'hBAD1BAD1
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      ihit,
  output word_t     iload,
  output logic      dhit,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  ramstate_t ramstate,
  input  word_t     ramload,
  output logic      err
);

  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam int RW = $clog2(MAX_RETRY + 2);

  arb_state_t     state, nxt;
  arb_req_t       req_q, gnt_req;
  arb_state_t     gnt_st;
  word_t          addr_q, store_q;
  logic [SW-1:0]  starve_cnt;
  logic [RW-1:0]  retry_cnt;
  logic           gap_q, drop_q;
  logic           starved, take_i, take_w, take_r;
  logic           gnt_v, line_now, live;

  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign live     = !drop_q && line_now;

  always_comb begin
    starved = iREN && (starve_cnt == SW'(STARVE_LIMIT));
    take_i  = iREN && (starved || !(dREN || dWEN));
    take_w  = dWEN && !take_i;
    take_r  = dREN && !dWEN && !take_i;
    gnt_v   = take_i || take_w || take_r;
    gnt_req = REQ_I;
    gnt_st  = IFETCH;
    unique case (1'b1)
      take_w: begin
        gnt_req = REQ_DW;
        gnt_st  = DWRITE;
      end
      take_r: begin
        gnt_req = REQ_DR;
        gnt_st  = DREAD;
      end
      default: ;
    endcase
  end

  always_comb begin
    line_now = 1'b0;
    unique case (req_q)
      REQ_I:   line_now = iREN;
      REQ_DR:  line_now = dREN;
      default: line_now = dWEN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= nxt;
  end

  // FREE, BUSY and any unknown encoding all hold the issue state
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:
        if (gnt_v) nxt = gnt_st;
      IFETCH, DREAD, DWRITE:
        if (!gap_q) begin
          if (ramstate == ACCESS)
            nxt = RESP;
          else if (ramstate == ERROR &&
                   retry_cnt >= RW'(MAX_RETRY))
            nxt = RESP;
        end
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    ramREN = 1'b0;
    ramWEN = 1'b0;
    ihit   = 1'b0;
    dhit   = 1'b0;
    unique case (state)
      IFETCH, DREAD: ramREN = !gap_q;
      DWRITE:        ramWEN = !gap_q;
      RESP: begin
        ihit = (req_q == REQ_I) && live;
        dhit = (req_q != REQ_I) && live;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      req_q      <= REQ_I;
      addr_q     <= '0;
      store_q    <= '0;
      iload      <= '0;
      dload      <= '0;
      starve_cnt <= '0;
      retry_cnt  <= '0;
      gap_q      <= 1'b0;
      drop_q     <= 1'b0;
      err        <= 1'b0;
    end else begin
      unique case (state)
        IDLE:
          if (gnt_v) begin
            req_q   <= gnt_req;
            addr_q  <= (gnt_req == REQ_I) ? iaddr : daddr;
            store_q <= dstore;
            drop_q  <= 1'b0;
            if (gnt_req == REQ_I || !iREN)
              starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_LIMIT))
              starve_cnt <= starve_cnt + 1'b1;
          end
        IFETCH, DREAD, DWRITE: begin
          if (!line_now) drop_q <= 1'b1;
          if (gap_q) begin
            gap_q <= 1'b0;
          end else if (ramstate == ACCESS) begin
            if (req_q == REQ_I)       iload <= ramload;
            else if (req_q == REQ_DR) dload <= ramload;
          end else if (ramstate == ERROR) begin
            if (retry_cnt < RW'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + 1'b1;
              gap_q     <= 1'b1;
            end else begin
              err <= 1'b1;
              if (req_q == REQ_I)       iload <= ERR_WORD;
              else if (req_q == REQ_DR) dload <= ERR_WORD;
            end
          end
        end
        RESP: begin
          retry_cnt <= '0;
          gap_q     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter with a
// transaction-level reference model and a responding RAM.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int          LIM = 4;
  localparam int          MR  = 2;
  localparam logic [31:0] EW  = 32'hBAD1BAD1;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        ihit, dhit, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  ramstate_t   ramstate;

  mem_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .iload(iload),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramstate(ramstate), .ramload(ramload),
    .err(err)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ram_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          starve_m = 0;
  bit          err_m = 1'b0;
  logic [31:0] exp_iload = '0;
  logic [31:0] exp_dload = '0;
  string       order;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0F0F0F0F;
  endfunction

  function automatic logic [31:0] rd_ram(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with the arbiter idle; returns likewise.
  // k = wait cycles on the final attempt, e = ERROR responses first.
  task automatic txn(input bit ir, input bit dr, input bit dw,
                     input logic [31:0] ia, input logic [31:0] da,
                     input logic [31:0] ds, input int k, input int e,
                     input bit wd);
    int          g, hc, sc, strobes, err_left, busy_left;
    bit          ab, exp_i, exp_d;
    logic [31:0] ea;
    if ((dw || dr) && !(starve_m >= LIM && ir)) g = dw ? 3 : 2;
    else                                        g = ir ? 1 : 0;
    if (g == 0) begin
      @(posedge CLK); #1;
      return;
    end
    if (g == 1 || !ir)    starve_m = 0;
    else if (starve_m < LIM) starve_m = starve_m + 1;
    ab    = (e > MR);
    hc    = ab ? 2 + 2 * MR : 2 + 2 * e + k;
    sc    = ab ? MR + 1 : e + 1 + k;
    ea    = (g == 1) ? ia : da;
    exp_i = (g == 1) && !wd;
    exp_d = (g != 1) && !wd;
    iREN = ir; dREN = dr; dWEN = dw;
    iaddr = ia; daddr = da; dstore = ds;
    ramstate = FREE;
    err_left = e; busy_left = k; strobes = 0;
    @(negedge CLK);
    chk("idle_strobe", {30'b0, ramREN, ramWEN}, 0);
    for (int c = 1; c <= hc; c++) begin
      @(posedge CLK); #1;
      if (c == 1) begin
        iaddr = $urandom; daddr = $urandom; dstore = $urandom;
        if (wd) begin
          case (g)
            1:       iREN = 1'b0;
            2:       dREN = 1'b0;
            default: dWEN = 1'b0;
          endcase
        end
      end
      ramstate = FREE;
      if (ramREN || ramWEN) begin
        strobes++;
        chk("strobe_type", {30'b0, ramREN, ramWEN}, (g == 3) ? 1 : 2);
        chk("ramaddr", ramaddr, ea);
        if (g == 3) chk("ramstore", ramstore, ds);
        if (err_left > 0) begin
          ramstate = ERROR;
          err_left--;
        end else if (busy_left > 0) begin
          ramstate = ($urandom_range(0, 1) == 1) ? BUSY : FREE;
          busy_left--;
        end else begin
          ramstate = ACCESS;
          if (ramWEN) ram_mem[ramaddr] = ramstore;
          else        ramload = rd_ram(ramaddr);
        end
      end
      @(negedge CLK);
      if (c < hc) chk("early_hit", {30'b0, ihit, dhit}, 0);
    end
    if (g == 1)      exp_iload = ab ? EW : rd_ref(ia);
    else if (g == 2) exp_dload = ab ? EW : rd_ref(da);
    else if (!ab)    ref_mem[da] = ds;
    err_m = err_m | ab;
    chk("hit", {30'b0, ihit, dhit}, {30'b0, exp_i, exp_d});
    chk("iload", iload, exp_iload);
    chk("dload", dload, exp_dload);
    chk("strobe_cycles", strobes, sc);
    chk("err", {31'b0, err}, {31'b0, err_m});
    order = {order, ihit ? "I" : (dhit ? "D" : "-")};
    @(posedge CLK); #1;
    ramstate = FREE;
  endtask

  initial begin
    bit          ir, dr, dw, wd;
    int          k, e;
    logic [31:0] ia, da;
    nRST = 1'b0;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramstate = FREE; ramload = '0;
    #12;
    chk("rst_hits", {30'b0, ihit, dhit}, 0);
    chk("rst_strobes", {30'b0, ramREN, ramWEN}, 0);
    chk("rst_iload", iload, 0);
    chk("rst_dload", dload, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_err", {31'b0, err}, 0);
    @(posedge CLK); #1;
    nRST = 1'b1;

    ram_mem[32'h40]  = 32'h8C220004;
    ref_mem[32'h40]  = 32'h8C220004;
    ram_mem[32'h100] = 32'h12345678;
    ref_mem[32'h100] = 32'h12345678;

    txn(1, 0, 0, 32'h40, 0, 0, 0, 0, 0);
    chk("ifetch_word", iload, 32'h8C220004);

    order = "";
    txn(1, 1, 0, 32'h40, 32'h100, 0, 0, 0, 0);
    chk("prio_dload", dload, 32'h12345678);
    txn(1, 0, 0, 32'h40, 0, 0, 0, 0, 0);
    checks++;
    assert (order == "DI") else begin
      errors++;
      $error("FAIL prio_order: got %s want DI", order);
    end

    order = "";
    for (int i = 0; i < 10; i++)
      txn(1, 1, 0, 32'h44, 32'h104, 0, 0, 0, 0);
    checks++;
    assert (order == "DDDDIDDDDI") else begin
      errors++;
      $error("FAIL starve_order: got %s want DDDDIDDDDI", order);
    end

    txn(0, 0, 1, 0, 32'h200, 32'hDEADBEEF, 3, 0, 0);
    chk("write_commit", rd_ram(32'h200), 32'hDEADBEEF);

    txn(0, 1, 0, 0, 32'h200, 0, 0, 1, 0);
    chk("retry_ok", dload, 32'hDEADBEEF);
    txn(0, 1, 0, 0, 32'h100, 0, 0, 5, 0);
    chk("abort_word", dload, 32'hBAD1BAD1);
    txn(1, 0, 0, 32'h40, 0, 0, 1, 0, 0);
    chk("err_sticky", {31'b0, err}, 1);

    txn(1, 0, 0, 32'h48, 0, 0, 1, 0, 1);
    txn(0, 0, 1, 0, 32'h24, 32'h0BADF00D, 2, 0, 1);
    txn(0, 1, 0, 0, 32'h24, 0, 0, 0, 0);

    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b1;
    daddr = 32'h300; dstore = 32'hCAFEF00D;
    ramstate = FREE;
    @(negedge CLK);
    @(posedge CLK); #1;
    chk("rst_mid_wen", {31'b0, ramWEN}, 1);
    ramstate = BUSY;
    #2 nRST = 1'b0;
    #1;
    chk("rst_mid_drop", {30'b0, ramREN, ramWEN}, 0);
    chk("rst_mid_err", {31'b0, err}, 0);
    dWEN = 1'b0;
    @(negedge CLK);
    chk("rst_mid_hit", {30'b0, ihit, dhit}, 0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    ramstate = FREE;
    @(negedge CLK);
    chk("rst_rel_idle", {28'b0, ramREN, ramWEN, ihit, dhit}, 0);
    @(posedge CLK); #1;
    starve_m = 0; err_m = 1'b0;
    exp_iload = '0; exp_dload = '0;
    txn(0, 1, 0, 0, 32'h300, 0, 0, 0, 0);

    for (int n = 0; n < 150; n++) begin
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      dw = ($urandom_range(0, 3) == 0);
      if (!ir && !dr && !dw) ir = 1'b1;
      wd = ($urandom_range(0, 9) == 0);
      k  = $urandom_range(0, 3);
      e  = ($urandom_range(0, 9) < 8) ? 0 : $urandom_range(1, 3);
      ia = 32'($urandom_range(0, 15)) << 2;
      da = 32'($urandom_range(0, 15)) << 2;
      txn(ir, dr, dw, ia, da, $urandom, k, e, wd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
